conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
Streaming 5x5 sliding-window generator. It is the producer end of the convolution datapath's map_block interface.
- Accepts one feature-map pixel per cycle in raster order.
- Buffers four previous rows.
- Presents every fully-populated ("valid"-mode, no padding) 5x5 window, registered, to the downstream 5x5 convolution point.
- Uses valid/ready handshakes on both sides, so it can sit between a pixel source and the convolution/accumulate stage.

Parameters:
bitwidth, 16, pixel width in bits (signed); matches the convolution point's operand width
map_width, 28, pixels per row (W), >= 5
map_height, 28, rows per frame (H), >= 5
Derived constants: CW = $clog2(map_width), RW = $clog2(map_height)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_pixel  input  signed [bitwidth-1:0]  incoming pixel, raster order (row-major, col 0 first)
in_valid  input  1  in_pixel is valid
in_ready  output  1  block accepts a pixel this cycle
window  output  signed [bitwidth-1:0] [4:0][4:0] (unpacked)  5x5 window; window[i][j] = pixel (out_row+i, out_col+j)
out_valid  output  1  window/out_row/out_col hold a valid window
out_ready  input  1  downstream consumes the window this cycle
out_row  output  [RW-1:0]  top-left row of the presented window
out_col  output  [CW-1:0]  top-left column of the presented window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync-deasserted externally) clears the following; line buffers are not reset.
  - out_valid=0, frame_done=0, out_row=0, out_col=0
  - all window registers = 0
  - col/row counters = 0
- Handshake: in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
  - Window registers double as the output register, so no shift occurs while a window is pending but not consumed.
- Counters col (0..W-1) and row (0..H-1) track the position of the next pixel and advance only on accept.
  - Column wraps W-1 -> 0 and increments row.
  - Row wraps H-1 -> 0, so back-to-back frames need no gap.
- Line buffer: 4 rows x W entries, lb[k][c] = pixel at (row-1-k, c).
  - On accept at column c: lb[0][c] <= in_pixel; lb[k][c] <= lb[k-1][c] for k = 1..3.
  - Read and write use the same index c in the same cycle; the read value is pre-update.
- On accept, column vector v = {lb[3][c], lb[2][c], lb[1][c], lb[0][c], in_pixel}, with v[0] the oldest row.
  - window[i][j] <= window[i][j+1] for j = 0..3.
  - window[i][4] <= v[i].
- out_valid, set/clear:
  - Next cycle after an accept: out_valid <= (row >= 4 && col >= 4), evaluated at the accepted pixel's position.
  - Else if out_ready: out_valid <= 0.
  - Else: hold.
- out_row/out_col: latch (row-4, col-4) together with the window.
- Latency: window visible exactly one cycle after the accepting edge of its bottom-right pixel.
- Throughput: 1 pixel/cycle with out_ready tied high.
- Output count per frame: (H-4)*(W-4), e.g. 576 for 28x28.
- Row start (col 0..3): the window contains pixels from the previous row's tail, and out_valid is not set for these positions.
- frame_done = 1 in the cycle after accepting (row=H-1, col=W-1); otherwise 0.
- Simultaneous out_valid && out_ready && in_valid: the window is consumed and the new pixel accepted in the same cycle, with no bubble.
- Reset mid-frame: in-flight window dropped; the next accepted pixel is treated as (0,0). Stale line-buffer data is never exposed because output requires row >= 4.
- in_pixel is ignored when not accepted. in_valid may drop at any time; state holds.
- No arithmetic: pixels pass through unmodified, with width and sign preserved.

Decomposition:
- Shared package conv_pkg holds:
  - KSIZE = 5
  - typedef window_t (signed [bitwidth-1:0] [KSIZE-1:0][KSIZE-1:0]), shared with the convolution point
- One sub-module, conv_line_buffer: parameterised depth W, width bitwidth, 4 rows, single read/write index, the shift-on-write column behaviour above.
- Counters, handshake and window shift stay in the top module.

Test Plan:
- W=H=6, pixel(r,c) = r*6+c, in_valid=1, out_ready=1:
  - exactly 4 windows, at (out_row,out_col) = (0,0),(0,1),(1,0),(1,1);
  - first window[i][j] = i*6+j (window[4][4] = 28), visible one cycle after pixel 28 is accepted;
  - frame_done pulses once, after pixel 35.
- Same stimulus with out_ready low for 3 cycles when the first window appears:
  - in_ready = 0 during the stall;
  - window stable at value 0 in [0][0];
  - no pixel lost; final output sequence identical to the unstalled run.
- W=H=5, ramp 0..24: exactly one window, window[i][j] = 5i+j, out_row=out_col=0.
- Two back-to-back 6x6 frames, second frame offset by +100:
  - 8 windows total;
  - the second frame's first window has [0][0] = 100, with no previous-frame data in it.
- rst_n pulsed low after 20 pixels (6x6), then a full ramp frame:
  - outputs immediately after the reset are 0 (out_valid=0, frame_done=0, out_row=out_col=0);
  - 4 windows exactly as in scenario 1.
- Random in_valid/out_ready toggling (50%), 28x28 signed random pixels: 576 windows, each equal to the golden-model 5x5 crop at (out_row,out_col).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the 5x5 convolution datapath.
package conv_pkg;
  localparam int KSIZE = 5;
  localparam int LB_ROWS = KSIZE - 1;
  localparam int BITWIDTH = 16;

  // Packed window as seen by the convolution point: [row][col][bit].
  typedef logic signed [KSIZE-1:0][KSIZE-1:0][BITWIDTH-1:0] window_t;
endpackage

// File: rtl/conv_line_buffer.sv
// Four-row line buffer; a write at column idx pushes the column one row deeper.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int depth    = 28,
  parameter int bitwidth = 16,
  parameter int iw       = $clog2(depth)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [iw-1:0]              idx,
  input  logic signed [bitwidth-1:0] din,
  output logic signed [bitwidth-1:0] taps [LB_ROWS]
);

  // mem[k][c] holds pixel (current_row-1-k, c); contents need no reset.
  logic signed [bitwidth-1:0] mem [LB_ROWS][depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[0][idx] <= din;
      for (int k = 1; k < LB_ROWS; k++) begin
        mem[k][idx] <= mem[k-1][idx];
      end
    end
  end

  // Taps are the pre-update column at the same index being written.
  always_comb begin
    for (int k = 0; k < LB_ROWS; k++) begin
      taps[k] = mem[k][idx];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 valid-mode sliding-window generator with registered window output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int bitwidth   = 16,
  parameter int map_width  = 28,
  parameter int map_height = 28,
  localparam int CW = $clog2(map_width),
  localparam int RW = $clog2(map_height)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [bitwidth-1:0] in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [bitwidth-1:0] window [KSIZE-1:0][KSIZE-1:0],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RW-1:0]              out_row,
  output logic [CW-1:0]              out_col,
  output logic                       frame_done
);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          win_pos;
  logic signed [bitwidth-1:0] taps [LB_ROWS];
  logic signed [bitwidth-1:0] v [KSIZE];

  // Valid/ready: a transfer happens on a rising edge where valid && ready.
  // The window registers are also the output register, so a new pixel may
  // only shift them in when the held window is absent or being consumed.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign last_col = (col == CW'(map_width - 1));
  assign last_row = (row == RW'(map_height - 1));
  assign win_pos  = (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));

  conv_line_buffer #(
    .depth    (map_width),
    .bitwidth (bitwidth),
    .iw       (CW)
  ) u_line_buffer (
    .clk   (clk),
    .wr_en (accept),
    .idx   (col),
    .din   (in_pixel),
    .taps  (taps)
  );

  // Column vector entering the window, oldest row at index 0.
  always_comb begin
    v[KSIZE-1] = in_pixel;
    for (int k = 0; k < LB_ROWS; k++) begin
      v[KSIZE-2-k] = taps[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE; j++) begin
          window[i][j] <= '0;
        end
      end
    end else begin
      frame_done <= accept && last_row && last_col;
      if (accept) begin
        for (int i = 0; i < KSIZE; i++) begin
          for (int j = 0; j < KSIZE - 1; j++) begin
            window[i][j] <= window[i][j+1];
          end
          window[i][KSIZE-1] <= v[i];
        end
        out_valid <= win_pos;
        out_row   <= row - RW'(KSIZE - 1);
        out_col   <= col - CW'(KSIZE - 1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 6x6, 5x5 and 28x28 instances against a crop-based window model.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int BW = 16;
  localparam int EW = 16 + KSIZE * KSIZE * BW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // shared stimulus, steered to one instance by sel
  logic signed [BW-1:0] ip;
  logic iv;
  logic out_rdy;
  int   sel;

  logic ir6, ov6, fd6;
  logic [2:0] row6, col6;
  logic signed [BW-1:0] w6 [4:0][4:0];
  logic ir5, ov5, fd5;
  logic [2:0] row5, col5;
  logic signed [BW-1:0] w5 [4:0][4:0];
  logic ir28, ov28, fd28;
  logic [4:0] row28, col28;
  logic signed [BW-1:0] w28 [4:0][4:0];

  conv_window_gen #(.bitwidth(BW), .map_width(6), .map_height(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_pixel(ip), .in_valid(iv && (sel == 0)),
    .in_ready(ir6), .window(w6), .out_valid(ov6),
    .out_ready((sel == 0) ? out_rdy : 1'b1),
    .out_row(row6), .out_col(col6), .frame_done(fd6));

  conv_window_gen #(.bitwidth(BW), .map_width(5), .map_height(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_pixel(ip), .in_valid(iv && (sel == 1)),
    .in_ready(ir5), .window(w5), .out_valid(ov5),
    .out_ready((sel == 1) ? out_rdy : 1'b1),
    .out_row(row5), .out_col(col5), .frame_done(fd5));

  conv_window_gen #(.bitwidth(BW), .map_width(28), .map_height(28)) dut28 (
    .clk(clk), .rst_n(rst_n), .in_pixel(ip), .in_valid(iv && (sel == 2)),
    .in_ready(ir28), .window(w28), .out_valid(ov28),
    .out_ready((sel == 2) ? out_rdy : 1'b1),
    .out_row(row28), .out_col(col28), .frame_done(fd28));

  // scoreboard state
  logic [BW-1:0] src_q [$];
  logic [EW-1:0] exp_q [$];
  int fr [$];
  int checks, errors;
  int cyc, acc_count, cur_w, cur_h;
  int first_br_cyc, first_ov_cyc, last_acc_cyc, fd_cyc, fd_count, win_count;
  int stall_left;
  bit stall_arm, rnd_in, rnd_out;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ov();
    case (sel) 0: return ov6; 1: return ov5; default: return ov28; endcase
  endfunction
  function automatic logic m_ir();
    case (sel) 0: return ir6; 1: return ir5; default: return ir28; endcase
  endfunction
  function automatic logic m_fd();
    case (sel) 0: return fd6; 1: return fd5; default: return fd28; endcase
  endfunction
  function automatic logic signed [BW-1:0] m_w(input int i, input int j);
    case (sel) 0: return w6[i][j]; 1: return w5[i][j]; default: return w28[i][j]; endcase
  endfunction

  function automatic logic [EW-1:0] pack_obs();
    logic [EW-1:0] p;
    p = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        p[(i*KSIZE+j)*BW +: BW] = m_w(i, j);
    case (sel)
      0: begin p[EW-1 -: 8] = 8'(row6); p[EW-9 -: 8] = 8'(col6); end
      1: begin p[EW-1 -: 8] = 8'(row5); p[EW-9 -: 8] = 8'(col5); end
      default: begin p[EW-1 -: 8] = 8'(row28); p[EW-9 -: 8] = 8'(col28); end
    endcase
    return p;
  endfunction

  // Model: a window at (r0,c0) is simply the 5x5 crop of the frame there.
  function automatic logic [EW-1:0] pack_exp(input int w, input int r0, input int c0);
    logic [EW-1:0] p;
    p = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        p[(i*KSIZE+j)*BW +: BW] = BW'(fr[(r0+i)*w + c0 + j]);
    p[EW-1 -: 8] = 8'(r0);
    p[EW-9 -: 8] = 8'(c0);
    return p;
  endfunction

  task automatic load_frame(input int w, input int h, input bit rand_pix, input int offset);
    int val;
    fr.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        val = rand_pix ? int'($urandom_range(0, 65535)) - 32768 : r*w + c + offset;
        fr.push_back(val);
        src_q.push_back(BW'(val));
      end
    for (int r0 = 0; r0 <= h - KSIZE; r0++)
      for (int c0 = 0; c0 <= w - KSIZE; c0++)
        exp_q.push_back(pack_exp(w, r0, c0));
  endtask

  task automatic clr_stats(input int s, input int w, input int h);
    sel = s; cur_w = w; cur_h = h;
    acc_count = 0; first_br_cyc = -1; first_ov_cyc = -1; last_acc_cyc = -1;
    fd_cyc = -1; fd_count = 0; win_count = 0; stall_left = 0;
    stall_arm = 0; rnd_in = 0; rnd_out = 0;
    src_q.delete(); exp_q.delete();
  endtask

  // driver: one clock, inputs at negedge, outputs sampled 1 time unit later
  task automatic cycle();
    bit stalling;
    int idx;
    @(negedge clk);
    cyc++;
    iv = (src_q.size() > 0) && (rnd_in ? ($urandom_range(0, 1) == 1) : 1'b1);
    ip = iv ? src_q[0] : BW'($urandom);
    if (stall_arm && m_ov()) begin stall_left = 3; stall_arm = 0; end
    stalling = (stall_left > 0);
    if (stalling) begin out_rdy = 1'b0; stall_left--; end
    else out_rdy = rnd_out ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    chk("in_ready", m_ir(), !m_ov() || out_rdy);
    if (stalling) begin
      chk("stall_in_ready", m_ir(), 0);
      chk("stall_valid", m_ov(), 1);
      chk("stall_w00", m_w(0, 0), 0);
    end
    if (m_ov() && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (m_fd()) begin fd_count++; fd_cyc = cyc; end
    if (m_ov() && out_rdy) begin
      win_count++;
      chk("window_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("window", pack_obs(), exp_q.pop_front());
    end
    if (iv && m_ir()) begin
      idx = acc_count % (cur_w * cur_h);
      if (idx == KSIZE*cur_w - cur_w + KSIZE - 1 && first_br_cyc < 0) first_br_cyc = cyc;
      if (idx == cur_w*cur_h - 1) last_acc_cyc = cyc;
      acc_count++;
      void'(src_q.pop_front());
    end
  endtask

  task automatic run(input int max_cyc);
    int n, idle;
    n = 0; idle = 0;
    while (n < max_cyc && idle < 4) begin
      cycle();
      n++;
      if (src_q.size() == 0 && !m_ov()) idle++; else idle = 0;
    end
    chk("run_completed", idle >= 4, 1);
    iv = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, m_ov(), 0);
    chk({tag, "_frame_done"}, m_fd(), 0);
    chk({tag, "_rowcol"}, {row6, col6}, 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; iv = 1'b0; ip = '0; out_rdy = 1'b1;
    clr_stats(0, 6, 6);
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    chk("por_w00", w6[0][0], 0);
    chk("por_w44", w6[4][4], 0);
    chk("por_dut28_valid", ov28, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6x6 ramp, free-flowing
    clr_stats(0, 6, 6);
    load_frame(6, 6, 0, 0);
    run(200);
    chk("s1_windows", win_count, 4);
    chk("s1_left", exp_q.size(), 0);
    chk("s1_frame_done_count", fd_count, 1);
    chk("s1_frame_done_cycle", fd_cyc, last_acc_cyc + 1);
    chk("s1_latency", first_ov_cyc, first_br_cyc + 1);

    // same frame with a 3-cycle downstream stall on the first window
    clr_stats(0, 6, 6);
    stall_arm = 1;
    load_frame(6, 6, 0, 0);
    run(200);
    chk("s2_windows", win_count, 4);
    chk("s2_left", exp_q.size(), 0);
    chk("s2_frame_done_count", fd_count, 1);

    // 5x5 ramp: one window
    clr_stats(1, 5, 5);
    load_frame(5, 5, 0, 0);
    run(200);
    chk("s3_windows", win_count, 1);
    chk("s3_left", exp_q.size(), 0);

    // two back-to-back 6x6 frames, second offset by 100
    clr_stats(0, 6, 6);
    load_frame(6, 6, 0, 0);
    load_frame(6, 6, 0, 100);
    run(300);
    chk("s4_windows", win_count, 8);
    chk("s4_left", exp_q.size(), 0);
    chk("s4_frame_done_count", fd_count, 2);

    // reset after 20 pixels, then a clean frame
    clr_stats(0, 6, 6);
    for (int k = 0; k < 20; k++) src_q.push_back(BW'(k));
    run(100);
    chk("s5_partial_windows", win_count, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_rst");
    chk("s5_rst_w44", w6[4][4], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_stats(0, 6, 6);
    load_frame(6, 6, 0, 0);
    run(200);
    chk("s5_windows", win_count, 4);
    chk("s5_left", exp_q.size(), 0);
    chk("s5_frame_done_count", fd_count, 1);

    // 28x28 signed random pixels with random in_valid / out_ready
    clr_stats(2, 28, 28);
    rnd_in = 1; rnd_out = 1;
    load_frame(28, 28, 1, 0);
    run(20000);
    chk("s6_windows", win_count, 576);
    chk("s6_left", exp_q.size(), 0);
    chk("s6_frame_done_count", fd_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
